// File: rtl/ddr3_app_bist.sv
// ddr3_app_bist: self-test traffic generator/checker on the DDR3 MIG app_* port.
// Writes an address-derived pattern over a block of bursts, reads it back and
// compares each returned beat. Everything runs in the ddr3_clk domain.
// Optional watchdog: define DDR3_BIST_TIMEOUT_EN to build a TO_W-bit stall timer.
module ddr3_app_bist #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 288,
    parameter int MASK_W    = 36,
    parameter int ADDR_STEP = 8,
    parameter int LEN_W     = 24,
    parameter int TO_W      = 16
) (
    input  logic                ddr3_clk,
    input  logic                ddr3_rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    num_bursts,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [LEN_W:0]      err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic                timeout,
    input  logic                app_rdy,
    input  logic                app_wdf_rdy,
    input  logic                app_rd_data_valid,
    input  logic                app_rd_data_end,
    input  logic [DATA_W-1:0]   app_rd_data,
    output logic                app_en,
    output logic [2:0]          app_cmd,
    output logic [ADDR_W-1:0]   app_addr,
    output logic [DATA_W-1:0]   app_wdf_data,
    output logic                app_wdf_wren,
    output logic                app_wdf_end,
    output logic [MASK_W-1:0]   app_wdf_mask
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [2:0]        CMD_WR  = 3'b000;
    localparam logic [2:0]        CMD_RD  = 3'b001;
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(ADDR_STEP);
    localparam logic [LEN_W-1:0]  ONE_LEN = LEN_W'(1);
    localparam logic [LEN_W:0]    ONE_CNT = (LEN_W+1)'(1);

    // Expected beat contents: the 32-bit burst address (xor beat index) replicated across the beat.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] addr, input logic beat);
        logic [31:0] word;
        word = 32'(addr) ^ {31'd0, beat};
        return {(DATA_W/32){word}};
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [LEN_W:0]      err_count_q, err_count_d;
    logic [ADDR_W-1:0]   first_err_addr_q, first_err_addr_d;
    logic                timeout_q, timeout_d;
    logic                app_en_q, app_en_d;
    logic [2:0]          app_cmd_q, app_cmd_d;
    logic [ADDR_W-1:0]   app_addr_q, app_addr_d;
    logic [DATA_W-1:0]   wdf_data_q, wdf_data_d;
    logic                wdf_wren_q, wdf_wren_d;
    logic                wdf_end_q, wdf_end_d;
    // command path: next address, commands presented, commands accepted
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [LEN_W-1:0]    cmd_sent_q, cmd_sent_d;
    logic [LEN_W-1:0]    cmd_done_q, cmd_done_d;
    // write data path: next burst address, current burst address, bursts started/finished
    logic [ADDR_W-1:0]   dat_addr_q, dat_addr_d;
    logic [ADDR_W-1:0]   dat_cur_q, dat_cur_d;
    logic [LEN_W-1:0]    dat_sent_q, dat_sent_d;
    logic [LEN_W-1:0]    dat_done_q, dat_done_d;
    // read checker: expected burst address/beat and beats received
    logic [ADDR_W-1:0]   chk_addr_q, chk_addr_d;
    logic                chk_beat_q, chk_beat_d;
    logic [LEN_W:0]      rd_beats_q, rd_beats_d;
`ifdef DDR3_BIST_TIMEOUT_EN
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
`endif

    logic cmd_fire_s;
    logic beat_fire_s;
    logic rd_take_s;
    logic rd_bad_s;

    // Handshake strobes seen at the next clock edge.
    always_comb begin
        cmd_fire_s  = app_en_q & app_rdy;
        beat_fire_s = wdf_wren_q & app_wdf_rdy;
        rd_take_s   = (state_q == S_READ) & app_rd_data_valid;
        // A beat is bad if its data differs or its end flag disagrees with the expected beat.
        rd_bad_s    = (app_rd_data != pattern(chk_addr_q, chk_beat_q)) ||
                      (app_rd_data_end != chk_beat_q);
    end

    // Next-state logic for the sequencer, command/data paths and checker.
    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        len_d            = len_q;
        busy_d           = busy_q;
        done_d           = done_q;
        err_d            = err_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        timeout_d        = timeout_q;
        app_en_d         = app_en_q;
        app_cmd_d        = app_cmd_q;
        app_addr_d       = app_addr_q;
        wdf_data_d       = wdf_data_q;
        wdf_wren_d       = wdf_wren_q;
        wdf_end_d        = wdf_end_q;
        cmd_addr_d       = cmd_addr_q;
        cmd_sent_d       = cmd_sent_q;
        cmd_done_d       = cmd_done_q;
        dat_addr_d       = dat_addr_q;
        dat_cur_d        = dat_cur_q;
        dat_sent_d       = dat_sent_q;
        dat_done_d       = dat_done_q;
        chk_addr_d       = chk_addr_q;
        chk_beat_d       = chk_beat_q;
        rd_beats_d       = rd_beats_q;
`ifdef DDR3_BIST_TIMEOUT_EN
        to_cnt_d         = to_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d           = base_addr;
                    len_d            = num_bursts;
                    busy_d           = 1'b1;
                    done_d           = 1'b0;
                    err_d            = 1'b0;
                    err_count_d      = '0;
                    first_err_addr_d = '0;
                    timeout_d        = 1'b0;
                    cmd_addr_d       = base_addr;
                    cmd_sent_d       = '0;
                    cmd_done_d       = '0;
                    dat_addr_d       = base_addr;
                    dat_cur_d        = base_addr;
                    dat_sent_d       = '0;
                    dat_done_d       = '0;
                    chk_addr_d       = base_addr;
                    chk_beat_d       = 1'b0;
                    rd_beats_d       = '0;
                    state_d          = (num_bursts == '0) ? S_FIN : S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_WRITE: begin
                // Command path: hold app_en until accepted, then present the next address.
                if (cmd_fire_s) begin
                    cmd_done_d = cmd_done_q + ONE_LEN;
                end else begin
                    cmd_done_d = cmd_done_q;
                end
                if (!app_en_q || cmd_fire_s) begin
                    if (cmd_sent_q != len_q) begin
                        app_en_d   = 1'b1;
                        app_cmd_d  = CMD_WR;
                        app_addr_d = cmd_addr_q;
                        cmd_addr_d = cmd_addr_q + STEP;
                        cmd_sent_d = cmd_sent_q + ONE_LEN;
                    end else begin
                        app_en_d = 1'b0;
                    end
                end else begin
                    app_en_d = 1'b1;
                end

                // Data path: beat0 then beat1; a new burst may start only once the
                // commands of all earlier bursts were accepted (lead of one burst).
                if (beat_fire_s && wdf_end_q) begin
                    dat_done_d = dat_done_q + ONE_LEN;
                end else begin
                    dat_done_d = dat_done_q;
                end
                if (!wdf_wren_q || beat_fire_s) begin
                    if (wdf_wren_q && !wdf_end_q) begin
                        wdf_wren_d = 1'b1;
                        wdf_end_d  = 1'b1;
                        wdf_data_d = pattern(dat_cur_q, 1'b1);
                    end else if ((dat_sent_q != len_q) && (dat_sent_q <= cmd_done_q)) begin
                        wdf_wren_d = 1'b1;
                        wdf_end_d  = 1'b0;
                        wdf_data_d = pattern(dat_addr_q, 1'b0);
                        dat_cur_d  = dat_addr_q;
                        dat_addr_d = dat_addr_q + STEP;
                        dat_sent_d = dat_sent_q + ONE_LEN;
                    end else begin
                        wdf_wren_d = 1'b0;
                        wdf_end_d  = 1'b0;
                    end
                end else begin
                    wdf_wren_d = 1'b1;
                end

                // Both paths complete: rewind the command path for the read pass.
                if ((cmd_done_q == len_q) && (dat_done_q == len_q)) begin
                    state_d    = S_READ;
                    cmd_addr_d = base_q;
                    cmd_sent_d = '0;
                    cmd_done_d = '0;
                    app_en_d   = 1'b0;
                    wdf_wren_d = 1'b0;
                    wdf_end_d  = 1'b0;
                end else begin
                    state_d = S_WRITE;
                end
            end

            S_READ: begin
                // Read commands back-to-back over the same addresses.
                if (!app_en_q || cmd_fire_s) begin
                    if (cmd_sent_q != len_q) begin
                        app_en_d   = 1'b1;
                        app_cmd_d  = CMD_RD;
                        app_addr_d = cmd_addr_q;
                        cmd_addr_d = cmd_addr_q + STEP;
                        cmd_sent_d = cmd_sent_q + ONE_LEN;
                    end else begin
                        app_en_d = 1'b0;
                    end
                end else begin
                    app_en_d = 1'b1;
                end

                if (rd_beats_q == {len_q, 1'b0}) begin
                    state_d  = S_FIN;
                    app_en_d = 1'b0;
                end else if (app_rd_data_valid) begin
                    // In-order return: compare against the tracked address/beat.
                    if (rd_bad_s) begin
                        err_d = 1'b1;
                        if (!err_q) begin
                            first_err_addr_d = chk_addr_q;
                        end else begin
                            first_err_addr_d = first_err_addr_q;
                        end
                        if (!(&err_count_q)) begin
                            err_count_d = err_count_q + ONE_CNT;
                        end else begin
                            err_count_d = err_count_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                    if (chk_beat_q) begin
                        chk_addr_d = chk_addr_q + STEP;
                    end else begin
                        chk_addr_d = chk_addr_q;
                    end
                    chk_beat_d = ~chk_beat_q;
                    rd_beats_d = rd_beats_q + ONE_CNT;
                end else begin
                    state_d = S_READ;
                end
            end

            S_FIN: begin
                busy_d     = 1'b0;
                done_d     = 1'b1;
                app_en_d   = 1'b0;
                wdf_wren_d = 1'b0;
                wdf_end_d  = 1'b0;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef DDR3_BIST_TIMEOUT_EN
        // Watchdog: any accepted command, write beat or read beat restarts the timer.
        if ((state_q == S_WRITE) || (state_q == S_READ)) begin
            if (cmd_fire_s || beat_fire_s || rd_take_s) begin
                to_cnt_d = '0;
            end else if (&to_cnt_q) begin
                timeout_d  = 1'b1;
                app_en_d   = 1'b0;
                wdf_wren_d = 1'b0;
                wdf_end_d  = 1'b0;
                state_d    = S_FIN;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
`else
        // No watchdog: a stalled MIG keeps the test busy until reset.
        timeout_d = 1'b0;
`endif
    end

`ifndef DDR3_BIST_TIMEOUT_EN
    // TO_W only sizes the watchdog timer, which this build leaves out.
    if (TO_W < 1) begin : g_to_w_unused
    end
`endif

    // State and output registers; async reset drops all handshakes at once.
    always_ff @(posedge ddr3_clk or negedge ddr3_rst_n) begin
        if (!ddr3_rst_n) begin
            state_q          <= S_IDLE;
            base_q           <= '0;
            len_q            <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            err_q            <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            timeout_q        <= 1'b0;
            app_en_q         <= 1'b0;
            app_cmd_q        <= 3'b000;
            app_addr_q       <= '0;
            wdf_data_q       <= '0;
            wdf_wren_q       <= 1'b0;
            wdf_end_q        <= 1'b0;
            cmd_addr_q       <= '0;
            cmd_sent_q       <= '0;
            cmd_done_q       <= '0;
            dat_addr_q       <= '0;
            dat_cur_q        <= '0;
            dat_sent_q       <= '0;
            dat_done_q       <= '0;
            chk_addr_q       <= '0;
            chk_beat_q       <= 1'b0;
            rd_beats_q       <= '0;
`ifdef DDR3_BIST_TIMEOUT_EN
            to_cnt_q         <= '0;
`endif
        end else begin
            state_q          <= state_d;
            base_q           <= base_d;
            len_q            <= len_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            err_q            <= err_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            timeout_q        <= timeout_d;
            app_en_q         <= app_en_d;
            app_cmd_q        <= app_cmd_d;
            app_addr_q       <= app_addr_d;
            wdf_data_q       <= wdf_data_d;
            wdf_wren_q       <= wdf_wren_d;
            wdf_end_q        <= wdf_end_d;
            cmd_addr_q       <= cmd_addr_d;
            cmd_sent_q       <= cmd_sent_d;
            cmd_done_q       <= cmd_done_d;
            dat_addr_q       <= dat_addr_d;
            dat_cur_q        <= dat_cur_d;
            dat_sent_q       <= dat_sent_d;
            dat_done_q       <= dat_done_d;
            chk_addr_q       <= chk_addr_d;
            chk_beat_q       <= chk_beat_d;
            rd_beats_q       <= rd_beats_d;
`ifdef DDR3_BIST_TIMEOUT_EN
            to_cnt_q         <= to_cnt_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign timeout        = timeout_q;
    assign app_en         = app_en_q;
    assign app_cmd        = app_cmd_q;
    assign app_addr       = app_addr_q;
    assign app_wdf_data   = wdf_data_q;
    assign app_wdf_wren   = wdf_wren_q;
    assign app_wdf_end    = wdf_end_q;
    assign app_wdf_mask   = '0;

endmodule

// File: tb/tb_ddr3_app_bist.sv
// Testbench for ddr3_app_bist: table of directed test runs against a MIG
// app-port model, plus hand-written sequences for latency, busy start,
// zero-length test, mid-test reset and (when built) the watchdog.
module tb_ddr3_app_bist;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 288;
    localparam int MASK_W = 36;
    localparam int LEN_W  = 24;

    logic                ddr3_clk;
    logic                ddr3_rst_n;
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [LEN_W-1:0]    num_bursts;
    logic                busy, done, err, timeout;
    logic [LEN_W:0]      err_count;
    logic [ADDR_W-1:0]   first_err_addr;
    logic                app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end;
    logic [DATA_W-1:0]   app_rd_data;
    logic                app_en;
    logic [2:0]          app_cmd;
    logic [ADDR_W-1:0]   app_addr;
    logic [DATA_W-1:0]   app_wdf_data;
    logic                app_wdf_wren, app_wdf_end;
    logic [MASK_W-1:0]   app_wdf_mask;

    ddr3_app_bist #(.TO_W(8)) dut (
        .ddr3_clk(ddr3_clk), .ddr3_rst_n(ddr3_rst_n), .start(start),
        .base_addr(base_addr), .num_bursts(num_bursts), .busy(busy), .done(done),
        .err(err), .err_count(err_count), .first_err_addr(first_err_addr),
        .timeout(timeout), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
        .app_rd_data(app_rd_data), .app_en(app_en), .app_cmd(app_cmd),
        .app_addr(app_addr), .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask)
    );

    initial ddr3_clk = 1'b0;
    always #5 ddr3_clk = ~ddr3_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] tb_pat(input logic [31:0] a, input logic b);
        logic [31:0] w;
        w = a ^ {31'd0, b};
        return {9{w}};
    endfunction

    // ---------------- MIG model configuration and scoreboard ----------------
    int          stall_pct = 0;
    bit          rdy_stuck = 1'b0;
    bit          corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = 32'd0;
    logic [1:0]  corrupt_beats = 2'b00;
    logic [31:0] tb_base = 32'd0;

    logic [31:0]       wr_cmd_q[$];
    logic [DATA_W-1:0] wr_beat_q[$];
    logic [31:0]       rd_q[$];
    logic [DATA_W-1:0] mem [bit [32:0]];
    int  wr_cmd_cnt = 0, rd_cmd_cnt = 0, wr_beat_cnt = 0, seq_bad = 0;
    bit  rd_beat = 1'b0;
    bit  en_seen = 1'b0;

    task automatic clear_sb();
        wr_cmd_q.delete(); wr_beat_q.delete(); rd_q.delete(); mem.delete();
        wr_cmd_cnt = 0; rd_cmd_cnt = 0; wr_beat_cnt = 0; seq_bad = 0;
        rd_beat = 1'b0; en_seen = 1'b0;
    endtask

    // MIG model: drives ready/read-return at negedge, records handshakes that fire at the next posedge.
    initial begin
        logic [31:0]       a;
        logic [DATA_W-1:0] d;
        logic [31:0]       exp_a;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data_valid = 1'b0;
        app_rd_data_end = 1'b0; app_rd_data = '0;
        forever begin
            @(negedge ddr3_clk);
            if (!ddr3_rst_n) begin
                wr_cmd_q.delete(); wr_beat_q.delete(); rd_q.delete();
                rd_beat = 1'b0;
                app_rdy = 1'b0; app_wdf_rdy = 1'b0;
                app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
            end else begin
                app_rd_data_valid = 1'b0;
                app_rd_data_end   = 1'b0;
                if (rd_q.size() > 0 && $urandom_range(99) >= stall_pct) begin
                    a = rd_q[0];
                    d = mem.exists({a, rd_beat}) ? mem[{a, rd_beat}] : '0;
                    if (corrupt_en && a == corrupt_addr && corrupt_beats[rd_beat]) d[5] = ~d[5];
                    app_rd_data       = d;
                    app_rd_data_valid = 1'b1;
                    app_rd_data_end   = rd_beat;
                    if (rd_beat) begin
                        void'(rd_q.pop_front());
                        rd_beat = 1'b0;
                    end else begin
                        rd_beat = 1'b1;
                    end
                end
                app_rdy     = !rdy_stuck && ($urandom_range(99) >= stall_pct);
                app_wdf_rdy = ($urandom_range(99) >= stall_pct);
                if (app_en) en_seen = 1'b1;
                if (app_en && app_rdy) begin
                    if (app_cmd == 3'b000) begin
                        exp_a = tb_base + 32'(wr_cmd_cnt * 8);
                        if (app_addr != exp_a) seq_bad++;
                        wr_cmd_q.push_back(app_addr);
                        wr_cmd_cnt++;
                    end else if (app_cmd == 3'b001) begin
                        exp_a = tb_base + 32'(rd_cmd_cnt * 8);
                        if (app_addr != exp_a) seq_bad++;
                        rd_q.push_back(app_addr);
                        rd_cmd_cnt++;
                    end else begin
                        seq_bad++;
                    end
                end
                if (app_wdf_wren && app_wdf_rdy) begin
                    exp_a = tb_base + 32'((wr_beat_cnt / 2) * 8);
                    if (app_wdf_data != tb_pat(exp_a, wr_beat_cnt[0])) seq_bad++;
                    if (app_wdf_end != wr_beat_cnt[0]) seq_bad++;
                    // data may lead its command by at most one burst
                    if (!wr_beat_cnt[0] && (wr_beat_cnt / 2) > wr_cmd_cnt) seq_bad++;
                    wr_beat_q.push_back(app_wdf_data);
                    wr_beat_cnt++;
                end
                while (wr_cmd_q.size() > 0 && wr_beat_q.size() >= 2) begin
                    a = wr_cmd_q.pop_front();
                    mem[{a, 1'b0}] = wr_beat_q.pop_front();
                    mem[{a, 1'b1}] = wr_beat_q.pop_front();
                end
            end
        end
    end

    // ---------------- stimulus table ----------------
    typedef struct {
        logic [31:0] base;
        logic [23:0] num;
        int          stall;
        bit          cor_en;
        logic [31:0] cor_addr;
        logic [1:0]  cor_beats;
        logic        exp_err;
        logic [24:0] exp_cnt;
        logic [31:0] exp_first;
    } vec_t;

    vec_t vecs[5];

    task automatic pulse_start(input logic [31:0] b, input logic [23:0] n);
        base_addr  = b;
        num_bursts = n;
        start      = 1'b1;
        @(negedge ddr3_clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (done) break;
            @(negedge ddr3_clk);
        end
        check({name, "_done_in_time"}, 64'(done), 64'd1);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        stall_pct     = v.stall;
        corrupt_en    = v.cor_en;
        corrupt_addr  = v.cor_addr;
        corrupt_beats = v.cor_beats;
        tb_base       = v.base;
        clear_sb();
        pulse_start(v.base, v.num);
        wait_done($sformatf("v%0d", i), 6000);
        check($sformatf("v%0d_busy", i),      64'(busy), 64'd0);
        check($sformatf("v%0d_err", i),       64'(err), 64'(v.exp_err));
        check($sformatf("v%0d_err_count", i), 64'(err_count), 64'(v.exp_cnt));
        check($sformatf("v%0d_first_err", i), 64'(first_err_addr), 64'(v.exp_first));
        check($sformatf("v%0d_wr_cmds", i),   64'(wr_cmd_cnt), 64'(v.num));
        check($sformatf("v%0d_rd_cmds", i),   64'(rd_cmd_cnt), 64'(v.num));
        check($sformatf("v%0d_wr_beats", i),  64'(wr_beat_cnt), 64'(2 * v.num));
        check($sformatf("v%0d_seq_bad", i),   64'(seq_bad), 64'd0);
        check($sformatf("v%0d_timeout", i),   64'(timeout), 64'd0);
    endtask

    initial begin
        int cyc;
        vecs[0] = '{32'h100,      24'd4,  0,  1'b0, 32'h0,   2'b00, 1'b0, 25'd0, 32'h0};
        vecs[1] = '{32'h100,      24'd4,  0,  1'b1, 32'h110, 2'b10, 1'b1, 25'd1, 32'h110};
        vecs[2] = '{32'h2000,     24'd16, 30, 1'b0, 32'h0,   2'b00, 1'b0, 25'd0, 32'h0};
        vecs[3] = '{32'hFFFFFFF0, 24'd4,  0,  1'b0, 32'h0,   2'b00, 1'b0, 25'd0, 32'h0};
        vecs[4] = '{32'h40,       24'd8,  30, 1'b1, 32'h48,  2'b11, 1'b1, 25'd2, 32'h48};

        ddr3_rst_n = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        num_bursts = '0;
        repeat (3) @(negedge ddr3_clk);

        // reset state
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_done",      64'(done), 64'd0);
        check("rst_err",       64'(err), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_app_en",    64'(app_en), 64'd0);
        check("rst_wren",      64'(app_wdf_wren), 64'd0);
        check("rst_timeout",   64'(timeout), 64'd0);
        check("rst_mask",      64'(app_wdf_mask), 64'd0);
        ddr3_rst_n = 1'b1;
        @(negedge ddr3_clk);

        for (int i = 0; i < 5; i++) run_vec(i);

        // start->app_en latency and start ignored while busy
        stall_pct = 0; corrupt_en = 1'b0; tb_base = 32'h100;
        clear_sb();
        base_addr = 32'h100; num_bursts = 24'd4; start = 1'b1;
        @(negedge ddr3_clk);
        check("lat_busy_c1",   64'(busy), 64'd1);
        check("lat_done_clr",  64'(done), 64'd0);
        check("lat_en_c1",     64'(app_en), 64'd0);
        base_addr = 32'h500; num_bursts = 24'd1;
        @(negedge ddr3_clk);
        start = 1'b0;
        check("lat_en_c2",     64'(app_en), 64'd1);
        check("lat_addr_c2",   64'(app_addr), 64'h100);
        check("lat_cmd_c2",    64'(app_cmd), 64'd0);
        wait_done("busy_start", 2000);
        check("busy_start_wr_cmds", 64'(wr_cmd_cnt), 64'd4);
        check("busy_start_rd_cmds", 64'(rd_cmd_cnt), 64'd4);
        check("busy_start_seq_bad", 64'(seq_bad), 64'd0);

        // zero-length test: done within 3 cycles, no app traffic
        clear_sb();
        pulse_start(32'h300, 24'd0);
        check("zero_busy_c1", 64'(busy), 64'd1);
        check("zero_done_c1", 64'(done), 64'd0);
        @(negedge ddr3_clk);
        check("zero_done_c2", 64'(done), 64'd1);
        check("zero_busy_c2", 64'(busy), 64'd0);
        repeat (3) @(negedge ddr3_clk);
        check("zero_no_app_en", 64'(en_seen), 64'd0);

        // reset asserted mid-WRITE drops outputs without a clock edge
        stall_pct = 30; tb_base = 32'h0;
        clear_sb();
        pulse_start(32'h0, 24'd16);
        for (int k = 0; k < 20; k++) begin
            if (app_en) break;
            @(negedge ddr3_clk);
        end
        check("mid_rst_en_before", 64'(app_en), 64'd1);
        #1 ddr3_rst_n = 1'b0;
        #1;
        check("mid_rst_app_en", 64'(app_en), 64'd0);
        check("mid_rst_wren",   64'(app_wdf_wren), 64'd0);
        check("mid_rst_busy",   64'(busy), 64'd0);
        check("mid_rst_done",   64'(done), 64'd0);
        @(negedge ddr3_clk);
        @(negedge ddr3_clk);
        ddr3_rst_n = 1'b1;
        @(negedge ddr3_clk);
        check("mid_rst_stays_idle", 64'(busy), 64'd0);

        // recovery run after reset
        run_vec(1);

`ifdef DDR3_BIST_TIMEOUT_EN
        // watchdog: app_rdy stuck low
        stall_pct = 0; rdy_stuck = 1'b1; tb_base = 32'h0;
        clear_sb();
        pulse_start(32'h0, 24'd4);
        cyc = 1;
        while (!done && cyc < 400) begin
            @(negedge ddr3_clk);
            cyc++;
        end
        check("to_timeout", 64'(timeout), 64'd1);
        check("to_done",    64'(done), 64'd1);
        check("to_app_en",  64'(app_en), 64'd0);
        check("to_latency_window", 64'((cyc >= 255) && (cyc <= 270)), 64'd1);
        rdy_stuck = 1'b0;
`else
        cyc = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
